// File: rtl/event_pulse_queue.sv
// Rising-edge detector over a synchronized bus: emits one-cycle pulses per bit
// and queues each non-zero rise mask in a small FIFO with sticky overflow.
module event_pulse_queue #(
   parameter int BUS_WIDTH  = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic [BUS_WIDTH-1:0]        SYNC_IN,
   input  logic                        EVT_READY,
   input  logic                        OVF_CLR,
   output logic [BUS_WIDTH-1:0]        PULSE,
   output logic [BUS_WIDTH-1:0]        EVT_DATA,
   output logic                        EVT_VALID,
   output logic                        FULL,
   output logic [$clog2(FIFO_DEPTH):0] LEVEL,
   output logic                        OVERFLOW
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);

   logic [BUS_WIDTH-1:0] prev_reg;
   logic [BUS_WIDTH-1:0] pulse_reg;
   logic [BUS_WIDTH-1:0] rise;

   logic [BUS_WIDTH-1:0] mem_reg [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_reg, wr_ptr_next;
   logic [PTR_W-1:0]     rd_ptr_reg, rd_ptr_next;
   logic [LVL_W-1:0]     level_reg, level_next;
   logic                 ovf_reg, ovf_next;

   logic push_req;
   logic push;
   logic pop;
   logic drop;
   logic full;
   logic valid;

   // Per-bit edge detector; a held-high level produces a single rise.
   generate
      for (genvar gi = 0; gi < BUS_WIDTH; gi++) begin : g_edge
         assign rise[gi] = SYNC_IN[gi] & ~prev_reg[gi];

         always_ff @(posedge CLK) begin
            if (RST) begin
               prev_reg[gi]  <= 1'b0;
               pulse_reg[gi] <= 1'b0;
            end else begin
               prev_reg[gi]  <= SYNC_IN[gi];
               pulse_reg[gi] <= rise[gi];
            end
         end
      end
   endgenerate

   assign valid    = (level_reg != '0);
   assign full     = (level_reg == DEPTH_L);
   assign push_req = |rise;
   assign pop      = valid & EVT_READY;
   // When full, a same-edge pop frees the slot the push is about to use.
   assign push     = push_req & (~full | pop);
   assign drop     = push_req & full & ~pop;

   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      level_next  = level_reg;
      ovf_next    = ovf_reg;

      if (push) begin
         wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      end

      case ({push, pop})
         2'b10:   level_next = level_reg + LVL_W'(1);
         2'b01:   level_next = level_reg - LVL_W'(1);
         default: level_next = level_reg;
      endcase

      // A drop on the same edge as a clear leaves the flag set.
      if (drop) begin
         ovf_next = 1'b1;
      end else if (OVF_CLR) begin
         ovf_next = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
         ovf_reg    <= 1'b0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         level_reg  <= level_next;
         ovf_reg    <= ovf_next;
      end
   end

   // Storage carries no reset; pointers and level alone define what is valid.
   always_ff @(posedge CLK) begin
      if (!RST && push) begin
         mem_reg[wr_ptr_reg] <= rise;
      end
   end

   assign PULSE     = pulse_reg;
   assign EVT_DATA  = valid ? mem_reg[rd_ptr_reg] : '0;
   assign EVT_VALID = valid;
   assign FULL      = full;
   assign LEVEL     = level_reg;
   assign OVERFLOW  = ovf_reg;

endmodule
